// File: rtl/rb_reader_pkg.sv
// ----------------------------------------------------------------------------
// rb_reader_pkg
//   Shared definitions for the MU result read-back path.
//   - Data, address and result widths used by both the writer and the reader.
//   - Number of words in one burst.
//   - Reader FSM state encoding.
//   - Tag that travels down the read-latency delay line.
//   - Helper that checks whether the unused high bits of a RAM word are set.
// ----------------------------------------------------------------------------
package rb_reader_pkg;

  localparam int MU_W        = 18;  // one MU result
  localparam int RAM_DW      = 32;  // result RAM word
  localparam int RAM_AW      = 8;   // result RAM word address
  localparam int BURST_WORDS = 4;   // MU1..MU4, shared with the writer
  localparam int IDX_W       = 2;   // selects a word within a burst

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } rb_state_t;

  // One issued read: vld marks an issue cycle, idx says which result it fills.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } rb_tag_t;

  // The writer only ever stores an 18-bit payload, so any set bit above it
  // means the RAM word is not something the writer produced.
  function automatic logic word_fmt_bad(input logic [RAM_DW-1:0] w);
    return |w[RAM_DW-1:MU_W];
  endfunction

endpackage

// File: rtl/rb_reader_if.sv
// ----------------------------------------------------------------------------
// rb_reader_if
//   Bundles the reader's request, RAM read port and result handshake.
//   slave  : the reader (rb_reader)
//   master : the environment (RAM read data + requester + result consumer)
//   Signals:
//     start, ptr_clr       request a 4-word read-back / clear word pointer
//     re_n, r_addr         RAM read enable (active low) and word address
//     rd_data              RAM read data, payload in [17:0]
//     res1..res4           reassembled MU1..MU4 results
//     out_valid, out_ready result handshake
//     busy, fmt_err        request in progress / sticky format error
// ----------------------------------------------------------------------------
interface rb_reader_if;
  import rb_reader_pkg::*;

  logic              start;
  logic              ptr_clr;
  logic              re_n;
  logic [RAM_AW-1:0] r_addr;
  logic [RAM_DW-1:0] rd_data;
  logic [MU_W-1:0]   res1;
  logic [MU_W-1:0]   res2;
  logic [MU_W-1:0]   res3;
  logic [MU_W-1:0]   res4;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              fmt_err;

  modport slave (
    input  start, ptr_clr, rd_data, out_ready,
    output re_n, r_addr, res1, res2, res3, res4, out_valid, busy, fmt_err
  );

  modport master (
    output start, ptr_clr, rd_data, out_ready,
    input  re_n, r_addr, res1, res2, res3, res4, out_valid, busy, fmt_err
  );

endinterface

// File: rtl/rb_lat_pipe.sv
// ----------------------------------------------------------------------------
// rb_lat_pipe
//   RD_LAT-deep delay line for issue tags. A tag entering in the cycle a
//   read is issued leaves exactly RD_LAT cycles later, which is the cycle
//   the RAM presents that word on rd_data; tag_out.vld is the capture strobe.
//   Ports:
//     clk, rst  clock, synchronous active-high reset (clears all stages)
//     tag_in    {vld, idx} of the read issued this cycle
//     tag_out   {vld, idx} of the read whose data is on rd_data this cycle
// ----------------------------------------------------------------------------
module rb_lat_pipe
  import rb_reader_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rb_tag_t tag_in,
  output rb_tag_t tag_out
);

  // Stage s holds the tag issued s cycles ago.
  logic [RD_LAT:1]            vld_pipe;
  logic [RD_LAT:1][IDX_W-1:0] idx_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[1] <= tag_in.vld;
      idx_pipe[1] <= tag_in.idx;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
    end
  end

  assign tag_out.vld = vld_pipe[RD_LAT];
  assign tag_out.idx = idx_pipe[RD_LAT];

endmodule

// File: rtl/rb_reader.sv
// ----------------------------------------------------------------------------
// rb_reader
//   Read-back counterpart of the MU write-back path. A start request reads
//   four consecutive result-RAM words (MU1..MU4 in write-back order),
//   reassembles them into res1..res4 and offers them with valid/ready.
//   The word pointer free-runs across requests so consecutive read-backs
//   walk the RAM in the same order the writer filled it.
//   Parameters:
//     RD_LAT  RAM read latency, address/re_n low to rd_data valid (1..3)
//     PTR_W   word pointer width; r_addr is the zero-extended pointer
//   Ports:
//     clk, rst  clock, synchronous active-high reset (aborts any request)
//     bus       rb_reader_if.slave: start/ptr_clr, RAM read port,
//               res1..res4 with out_valid/out_ready, busy, fmt_err
// ----------------------------------------------------------------------------
module rb_reader
  import rb_reader_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int PTR_W  = 6
) (
  input  logic       clk,
  input  logic       rst,
  rb_reader_if.slave bus
);

  rb_state_t                         state;
  logic [PTR_W-1:0]                  ptr;
  logic [PTR_W-1:0]                  ptr_nxt;
  logic [IDX_W-1:0]                  idx;
  logic                              re_n_q;
  logic [RAM_AW-1:0]                 r_addr_q;
  logic [BURST_WORDS-1:0][MU_W-1:0]  res_q;
  logic                              out_valid_q;
  logic                              busy_q;
  logic                              fmt_err_q;
  rb_tag_t                           iss_tag;
  rb_tag_t                           cap_tag;

  // Every ISSUE cycle sends one read into the latency line.
  always_comb begin
    iss_tag.vld = (state == ST_ISSUE);
    iss_tag.idx = idx;
  end

  // During ISSUE, ptr is the address being read this cycle. ptr_nxt is the
  // next address; ptr_clr overrides the increment, so a clear during ISSUE
  // keeps this cycle's address and makes the following issue use 0.
  always_comb begin
    ptr_nxt = ptr;
    if (bus.ptr_clr)
      ptr_nxt = '0;
    else if (state == ST_ISSUE)
      ptr_nxt = ptr + PTR_W'(1);
  end

  rb_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (iss_tag),
    .tag_out (cap_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      idx         <= '0;
      re_n_q      <= 1'b1;
      r_addr_q    <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      fmt_err_q   <= 1'b0;
    end else begin
      ptr <= ptr_nxt;

      // Captures run off the delay line alone, independent of state.
      if (cap_tag.vld) begin
        res_q[cap_tag.idx] <= bus.rd_data[MU_W-1:0];
        if (word_fmt_bad(bus.rd_data))
          fmt_err_q <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state    <= ST_ISSUE;
            busy_q   <= 1'b1;
            re_n_q   <= 1'b0;
            r_addr_q <= RAM_AW'(ptr_nxt);
            idx      <= '0;
          end
        end

        ST_ISSUE: begin
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state  <= ST_WAIT;
            re_n_q <= 1'b1;       // r_addr keeps the last issued address
          end else begin
            r_addr_q <= RAM_AW'(ptr_nxt);
          end
        end

        // The last word lands at the edge that ends this state.
        ST_WAIT: begin
          if (cap_tag.vld && (cap_tag.idx == LAST_IDX)) begin
            state       <= ST_HOLD;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        // start is deliberately not looked at here, so a request that
        // coincides with the handshake is dropped rather than queued.
        ST_HOLD: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.re_n      = re_n_q;
  assign bus.r_addr    = r_addr_q;
  assign bus.res1      = res_q[0];
  assign bus.res2      = res_q[1];
  assign bus.res3      = res_q[2];
  assign bus.res4      = res_q[3];
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.fmt_err   = fmt_err_q;

endmodule

// File: tb/tb_rb_reader.sv
// ----------------------------------------------------------------------------
// tb_rb_reader
//   Directed bench for rb_reader. dut1 runs with RD_LAT=1, dut3 with
//   RD_LAT=3; each has a small behavioural result RAM whose read data is
//   all-ones (format-invalid) in cycles that do not follow a real read.
// ----------------------------------------------------------------------------
module tb_rb_reader;
  import rb_reader_pkg::*;

  logic  clk;
  logic  rst1;
  logic  rst3;
  int    passes = 0;
  int    total  = 0;
  string phase  = "";

  rb_reader_if bus1 ();
  rb_reader_if bus3 ();

  rb_reader #(.RD_LAT(1), .PTR_W(6)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  rb_reader #(.RD_LAT(3), .PTR_W(6)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rd1_q;
  logic [31:0] rd3_p [3];

  always @(posedge clk) rd1_q <= bus1.re_n ? 32'hFFFF_FFFF : mem1[bus1.r_addr];
  assign bus1.rd_data = rd1_q;

  always @(posedge clk) begin
    rd3_p[0] <= bus3.re_n ? 32'hFFFF_FFFF : mem3[bus3.r_addr];
    rd3_p[1] <= rd3_p[0];
    rd3_p[2] <= rd3_p[1];
  end
  assign bus3.rd_data = rd3_p[2];

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s.%s: observed %0h expected %0h", phase, tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One dut1 request starting at the current negedge; ends in the first
  // cycle out_valid is expected high (5 cycles after the accepting edge).
  task automatic burst1(input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [7:0] a3,
                        input logic clr2);
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    chk("busy",  32'(bus1.busy), 1);
    chk("re_n0", 32'(bus1.re_n), 0);
    chk("addr0", 32'(bus1.r_addr), 32'(a0));
    tick();
    chk("addr1", 32'(bus1.r_addr), 32'(a1));
    bus1.ptr_clr = clr2;
    tick();
    bus1.ptr_clr = 1'b0;
    chk("addr2", 32'(bus1.r_addr), 32'(a2));
    tick();
    chk("addr3", 32'(bus1.r_addr), 32'(a3));
    chk("re_n3", 32'(bus1.re_n), 0);
    tick();
    chk("re_n_wait", 32'(bus1.re_n), 1);
    chk("ov_wait",   32'(bus1.out_valid), 0);
    tick();
    chk("ov",        32'(bus1.out_valid), 1);
    chk("busy_hold", 32'(bus1.busy), 0);
    chk("res1", 32'(bus1.res1), 32'(mem1[a0][17:0]));
    chk("res2", 32'(bus1.res2), 32'(mem1[a1][17:0]));
    chk("res3", 32'(bus1.res3), 32'(mem1[a2][17:0]));
    chk("res4", 32'(bus1.res4), 32'(mem1[a3][17:0]));
  endtask

  task automatic finish1();
    bus1.out_ready = 1'b1;
    tick();
    chk("ov_done",   32'(bus1.out_valid), 0);
    chk("busy_done", 32'(bus1.busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'(i * 257);
      mem3[i] = 32'(i * 257);
    end
    mem1[0] = 32'h0001_1; mem1[1] = 32'h0002_2; mem1[2] = 32'h0003_3; mem1[3] = 32'h0003_FFFF;
    mem3[0] = 32'h0001_1; mem3[1] = 32'h0002_2; mem3[2] = 32'h0003_3; mem3[3] = 32'h0003_FFFF;

    rst1 = 1'b1; rst3 = 1'b1;
    bus1.start = 1'b0; bus1.ptr_clr = 1'b0; bus1.out_ready = 1'b0;
    bus3.start = 1'b0; bus3.ptr_clr = 1'b0; bus3.out_ready = 1'b0;
    tick(); tick();

    phase = "reset";
    chk("re_n",   32'(bus1.re_n), 1);
    chk("r_addr", 32'(bus1.r_addr), 0);
    chk("ov",     32'(bus1.out_valid), 0);
    chk("busy",   32'(bus1.busy), 0);
    chk("fmt",    32'(bus1.fmt_err), 0);
    chk("res1",   32'(bus1.res1), 0);
    chk("res4",   32'(bus1.res4), 0);
    chk("re_n3",  32'(bus3.re_n), 1);
    rst1 = 1'b0; rst3 = 1'b0;

    // First burst: addresses 0..3, hand-loaded words
    phase = "b0";
    bus1.out_ready = 1'b1;
    burst1(8'd0, 8'd1, 8'd2, 8'd3, 1'b0);
    chk("res1_hand", 32'(bus1.res1), 32'h00011);
    chk("res4_hand", 32'(bus1.res4), 32'h3FFFF);
    chk("fmt",       32'(bus1.fmt_err), 0);
    finish1();

    phase = "b1";
    burst1(8'd4, 8'd5, 8'd6, 8'd7, 1'b0);
    chk("res1_hand", 32'(bus1.res1), 32'h00404);
    finish1();

    // Consumer stalls; start pulses in HOLD must be ignored
    phase = "stall";
    bus1.out_ready = 1'b0;
    burst1(8'd8, 8'd9, 8'd10, 8'd11, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus1.start = i[0];
      tick();
      chk("ov",   32'(bus1.out_valid), 1);
      chk("re_n", 32'(bus1.re_n), 1);
      chk("res1", 32'(bus1.res1), 32'h00808);
      chk("res4", 32'(bus1.res4), 32'h00B0B);
    end
    bus1.start = 1'b1;
    bus1.out_ready = 1'b1;
    tick();
    bus1.start = 1'b0;
    chk("ov_hs", 32'(bus1.out_valid), 0);
    tick();
    chk("busy_nq", 32'(bus1.busy), 0);
    chk("re_n_nq", 32'(bus1.re_n), 1);
    tick();
    chk("re_n_nq2", 32'(bus1.re_n), 1);

    // ptr_clr in the 2nd issue cycle: 12, 13, then restart at 0
    phase = "clr_mid";
    burst1(8'd12, 8'd13, 8'd0, 8'd1, 1'b1);
    finish1();

    phase = "walk";
    for (int b = 2; b <= 58; b += 4) begin
      burst1(8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3), 1'b0);
      finish1();
    end

    phase = "wrap";
    burst1(8'd62, 8'd63, 8'd0, 8'd1, 1'b0);
    finish1();

    phase = "walk2";
    for (int b = 2; b <= 58; b += 4) begin
      burst1(8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3), 1'b0);
      finish1();
    end

    phase = "wrap_clr";
    burst1(8'd62, 8'd63, 8'd0, 8'd1, 1'b1);
    finish1();

    phase = "after_clr";
    burst1(8'd2, 8'd3, 8'd4, 8'd5, 1'b0);
    finish1();

    // ptr_clr while idle, with a malformed word at address 1
    phase = "clr_idle";
    mem1[1] = 32'h0004_0005;
    bus1.ptr_clr = 1'b1;
    tick();
    bus1.ptr_clr = 1'b0;
    tick();
    burst1(8'd0, 8'd1, 8'd2, 8'd3, 1'b0);
    chk("res2_hand", 32'(bus1.res2), 32'h00005);
    chk("fmt",       32'(bus1.fmt_err), 1);
    finish1();

    phase = "fmt_sticky";
    burst1(8'd4, 8'd5, 8'd6, 8'd7, 1'b0);
    chk("fmt", 32'(bus1.fmt_err), 1);
    finish1();
    chk("fmt_idle", 32'(bus1.fmt_err), 1);

    phase = "rst1";
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk("fmt",    32'(bus1.fmt_err), 0);
    chk("res2",   32'(bus1.res2), 0);
    chk("r_addr", 32'(bus1.r_addr), 0);

    // RD_LAT=3: out_valid 7 cycles after the accepting edge
    phase = "lat3";
    bus3.out_ready = 1'b1;
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    chk("addr0", 32'(bus3.r_addr), 0);
    chk("re_n0", 32'(bus3.re_n), 0);
    tick(); tick(); tick();
    chk("addr3", 32'(bus3.r_addr), 3);
    tick();
    chk("re_n_wait", 32'(bus3.re_n), 1);
    chk("ov_w1",     32'(bus3.out_valid), 0);
    chk("busy_w1",   32'(bus3.busy), 1);
    tick(); tick();
    chk("ov_w3",     32'(bus3.out_valid), 0);
    chk("busy_w3",   32'(bus3.busy), 1);
    tick();
    chk("ov",   32'(bus3.out_valid), 1);
    chk("busy", 32'(bus3.busy), 0);
    chk("res1", 32'(bus3.res1), 32'h00011);
    chk("res2", 32'(bus3.res2), 32'h00022);
    chk("res3", 32'(bus3.res3), 32'h00033);
    chk("res4", 32'(bus3.res4), 32'h3FFFF);
    chk("fmt",  32'(bus3.fmt_err), 0);
    tick();
    chk("ov_done", 32'(bus3.out_valid), 0);

    // Reset in the 2nd WAIT cycle aborts the request
    phase = "rst3";
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    chk("addr0", 32'(bus3.r_addr), 4);
    tick(); tick(); tick(); tick();
    tick();
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    chk("ov",     32'(bus3.out_valid), 0);
    chk("busy",   32'(bus3.busy), 0);
    chk("re_n",   32'(bus3.re_n), 1);
    chk("r_addr", 32'(bus3.r_addr), 0);
    chk("res1",   32'(bus3.res1), 0);
    chk("fmt",    32'(bus3.fmt_err), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ov_after", 32'(bus3.out_valid), 0);
      chk("res4_after", 32'(bus3.res4), 0);
      chk("fmt_after", 32'(bus3.fmt_err), 0);
    end

    phase = "fresh3";
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    chk("addr0", 32'(bus3.r_addr), 0);
    for (int i = 0; i < 7; i++) tick();
    chk("ov",   32'(bus3.out_valid), 1);
    chk("res1", 32'(bus3.res1), 32'h00011);
    chk("res2", 32'(bus3.res2), 32'h00022);
    tick();
    chk("ov_done", 32'(bus3.out_valid), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/rb_reader.md
Name: rb_reader

Overview:
- Read-back counterpart of the MU write-back path.
- On a start request, reads four consecutive words from the result RAM through its read port. Word 0 becomes MU1, word 1 MU2, word 2 MU3, word 3 MU4, matching the write-back order.
- Presents the four reassembled 18-bit results to a consumer with a valid/ready handshake.
- Sits between the result SRAM read port and downstream logic (debug readout / next processing stage).

Parameters:
- RD_LAT, 1, SRAM read latency in cycles from address/re_n low to rd_data valid; legal 1..3.
- PTR_W, 6, width of the internal RAM word pointer; r_addr is zero-extended to 8 bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request one 4-word read-back; single-cycle pulse or level
- ptr_clr  input  1  synchronously reset the word pointer to 0
- re_n  output  1  RAM read enable, active low
- r_addr  output  8  RAM word address, {2'b00, ptr} for PTR_W=6
- rd_data  input  32  RAM read data; bits [17:0] payload, [31:18] expected zero
- res1, res2, res3, res4  output  18 each  reassembled results
- out_valid  output  1  results valid; held until out_ready
- out_ready  input  1  consumer accepts results
- busy  output  1  high from the accepted start until out_valid is raised
- fmt_err  output  1  sticky: some captured word had nonzero rd_data[31:18]

Behaviour:
- Reset values (rst high at a clock edge):
  - state=IDLE, ptr=0, re_n=1, r_addr=0.
  - res1..res4=0, out_valid=0, busy=0, fmt_err=0.
  - Pipeline tags cleared.
  - Reset mid-operation aborts immediately; no partial out_valid follows.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - start=1 is accepted: next state ISSUE, busy=1.
  - start is sampled only in IDLE. In ISSUE/WAIT/HOLD it is ignored, not queued.
- ISSUE (exactly 4 cycles, issue index i=0..3):
  - re_n=0, r_addr=ptr, ptr increments by 1 each cycle.
  - ptr wraps from 2^PTR_W-1 to 0.
  - After i=3, go to WAIT.
- Capture:
  - A shift register of depth RD_LAT carries {issued, index}.
  - rd_data is captured into the result register selected by index exactly RD_LAT cycles after issue: index 0 to res1, 1 to res2, 2 to res3, 3 to res4.
  - On each capture, if rd_data[31:18] != 0, set fmt_err. fmt_err is cleared only by rst.
- WAIT: lasts RD_LAT cycles, until the index-3 capture edge. Then go to HOLD: out_valid=1, busy=0.
- Latency: with start accepted at edge E0, the first issue cycle follows E0 and out_valid rises 4+RD_LAT cycles after E0.
- HOLD:
  - res1..res4 stable, out_valid=1.
  - out_valid && out_ready at a clock edge: out_valid=0 next cycle, go to IDLE.
  - start in that same cycle is ignored; start is accepted from IDLE on the next cycle.
  - res values are retained after the handshake until overwritten by the next capture.
- ptr_clr:
  - Sets ptr=0 at the edge.
  - If asserted during ISSUE, the current cycle's address is still used, and the next issue continues from 0.
  - ptr_clr and the ISSUE increment in the same cycle: ptr_clr wins.
- Back-to-back: ptr is not reset between requests, so consecutive read-backs walk the RAM in order, mirroring the writer's free-running address.
- re_n is high in every non-ISSUE cycle. r_addr holds its last value when idle.

Decomposition:
- Shared package:
  - State encoding constants (IDLE/ISSUE/WAIT/HOLD).
  - MU result width (18), RAM data width (32), RAM address width (8).
  - Words-per-burst constant (4), also used by the writer.
- One natural sub-module: rb_lat_pipe, the RD_LAT-deep {valid, index} delay line that generates capture strobes.

Test Plan:
- Reset, RAM preloaded addr0..3 = 0x00011, 0x00022, 0x00033, 0x3FFFF; start pulse, out_ready=1, RD_LAT=1 -> re_n low 4 cycles with r_addr 0,1,2,3; out_valid 5 cycles after the start edge; res1..4 = 0x00011, 0x00022, 0x00033, 0x3FFFF; fmt_err=0.
- Second start after the handshake -> r_addr 4..7, and results equal the RAM contents at 4..7.
- out_ready held low 10 cycles in HOLD while start pulses -> out_valid and res stable; no extra re_n activity; one completion after out_ready=1.
- Pointer at 62, ptr_clr=0 -> addresses 62, 63, 0, 1; with ptr_clr pulsed during the 2nd issue cycle -> addresses 62, 63, 0, 1 then next burst starts at 2. Repeat with ptr_clr asserted in IDLE -> next burst starts at 0.
- RAM addr1 = 0x0004_0005 -> res2 = 0x00005, fmt_err=1 and sticky across later clean bursts until rst.
- rst asserted in the 2nd WAIT cycle with RD_LAT=3 -> all outputs at reset values next cycle, no out_valid; a fresh start reads from addr 0.
